// File: rtl/alarm_match_controller_pkg.sv
// alarm_match_controller_pkg: shared state encoding, time word layout and BCD helpers
package alarm_match_controller_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZED = 2'd3} state_t;
  typedef logic [15:0] bcd_time_t;
  localparam int M0_LSB = 0;
  localparam int H0_LSB = 8;
  localparam int DIGIT_BASE = 10;
  localparam int MINS_PER_HOUR = 60;
  localparam int HOURS_PER_DAY = 24;
  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'(DIGIT_BASE) + 7'(b[3:0]);
  endfunction
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'(DIGIT_BASE)), 4'(v % 7'(DIGIT_BASE))};
  endfunction
endpackage

// File: rtl/alarm_match_controller_if.sv
// alarm_match_controller_if: time/alarm inputs, request pulses and ring outputs
interface alarm_match_controller_if;
  import alarm_match_controller_pkg::*;
  bcd_time_t count;
  bcd_time_t alarm_time;
  logic alarm_en;
  logic sec_tick;
  logic snooze;
  logic stop;
  logic ring;
  logic snoozing;
  logic alarm_hit;
  modport master (output count, alarm_time, alarm_en, sec_tick, snooze, stop, input ring, snoozing, alarm_hit);
  modport slave (input count, alarm_time, alarm_en, sec_tick, snooze, stop, output ring, snoozing, alarm_hit);
endinterface

// File: rtl/bcd_time_add.sv
// bcd_time_add: adds a 0..59 minute increment to an HHMM BCD time, wrapping at 23:59
module bcd_time_add
  import alarm_match_controller_pkg::*;
(
  input  bcd_time_t  t,
  input  logic [5:0] inc,
  output bcd_time_t  sum
);
  logic [6:0] m_sum, m_wrap, h_sum, h_wrap;
  logic carry;
  always_comb begin
    m_sum = bcd2bin(t[M0_LSB +: 8]) + 7'(inc);
    carry = m_sum >= 7'(MINS_PER_HOUR);
    m_wrap = carry ? m_sum - 7'(MINS_PER_HOUR) : m_sum;
    h_sum = bcd2bin(t[H0_LSB +: 8]) + 7'(carry);
    h_wrap = h_sum >= 7'(HOURS_PER_DAY) ? h_sum - 7'(HOURS_PER_DAY) : h_sum;
    sum = {bin2bcd(h_wrap), bin2bcd(m_wrap)};
  end
endmodule

// File: rtl/alarm_match_controller.sv
// alarm_match_controller: alarm FSM with edge-triggered match, snooze, snooze limit and ring timeout
module alarm_match_controller
  import alarm_match_controller_pkg::*;
#(
  parameter int SNOOZE_MIN = 9,
  parameter int SNOOZE_MAX = 3,
  parameter int RING_SECS  = 60
) (
  input logic clk,
  input logic clr,
  alarm_match_controller_if.slave bus
);
  state_t state, next;
  bcd_time_t snooze_target, snooze_sum, target;
  logic match, match_q, trigger, ringing, timeout, do_snooze, entering;
  logic ring_q, snoozing_q, hit_q;
  logic [7:0] ring_cnt;
  logic [3:0] snooze_cnt;
  bcd_time_add u_add (.t(bus.count), .inc(6'(SNOOZE_MIN)), .sum(snooze_sum));
  assign target = state == SNOOZED ? snooze_target : bus.alarm_time;
  assign match = bus.count == target;
  assign trigger = match & ~match_q;
  assign ringing = state == RINGING;
  assign timeout = ringing & bus.sec_tick & (ring_cnt == 8'(RING_SECS - 1));
  assign do_snooze = ringing & bus.snooze & ~bus.stop & (snooze_cnt < 4'(SNOOZE_MAX));
  assign entering = next == RINGING && !ringing;
  always_comb begin
    next = state;
    case (state)
      OFF:     next = ARMED;
      ARMED:   next = trigger ? RINGING : ARMED;
      RINGING: next = do_snooze ? SNOOZED : (bus.stop | bus.snooze | timeout) ? ARMED : RINGING;
      SNOOZED: next = bus.stop ? ARMED : trigger ? RINGING : SNOOZED;
      default: next = OFF;
    endcase
    if (!bus.alarm_en) next = OFF;
  end
  // match_q held low in OFF so enabling inside the matching minute still rings
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= OFF;
      match_q <= 1'b0;
      ring_q <= 1'b0;
      snoozing_q <= 1'b0;
      hit_q <= 1'b0;
      ring_cnt <= '0;
      snooze_cnt <= '0;
      snooze_target <= '0;
    end else begin
      state <= next;
      match_q <= state == OFF ? 1'b0 : match;
      ring_q <= next == RINGING;
      snoozing_q <= next == SNOOZED;
      hit_q <= entering;
      ring_cnt <= entering ? 8'd0 : (ringing && bus.sec_tick) ? ring_cnt + 8'd1 : ring_cnt;
      snooze_cnt <= (next == SNOOZED && ringing) ? snooze_cnt + 4'd1 :
                    (next == OFF || next == ARMED || state == ARMED) ? 4'd0 : snooze_cnt;
      snooze_target <= (next == SNOOZED && ringing) ? snooze_sum : snooze_target;
    end
  end
  assign bus.ring = ring_q;
  assign bus.snoozing = snoozing_q;
  assign bus.alarm_hit = hit_q;
endmodule

// File: tb/tb_alarm_match_controller.sv
// tb_alarm_match_controller: directed vectors with a per-cycle expected-output scoreboard
module tb_alarm_match_controller;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  string name_q[$];
  localparam logic [2:0] Z = 3'b000, S = 3'b010, R = 3'b100, RH = 3'b101;
  alarm_match_controller_if bus ();
  alarm_match_controller #(.SNOOZE_MIN(9), .SNOOZE_MAX(3), .RING_SECS(5)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: {ring,snoozing,hit} got %b expected %b at %0t", nm, act, e, $time);
    end
  endtask
  task automatic push(input logic [2:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  task automatic cyc(input logic [15:0] c, input logic en, tick, snz, stp, input logic [2:0] e, input string nm);
    @(negedge clk);
    bus.count = c;
    bus.alarm_en = en;
    bus.sec_tick = tick;
    bus.snooze = snz;
    bus.stop = stp;
    push(e, nm);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check(name_q.pop_front(), {bus.ring, bus.snoozing, bus.alarm_hit}, exp_q.pop_front());
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.count = 16'h0000;
    bus.alarm_time = 16'h0630;
    bus.alarm_en = 1'b0;
    bus.sec_tick = 1'b0;
    bus.snooze = 1'b0;
    bus.stop = 1'b0;
    #3 check("reset_async", {bus.ring, bus.snoozing, bus.alarm_hit}, Z);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", {bus.ring, bus.snoozing, bus.alarm_hit}, Z);
    clr = 1'b0;
    cyc(16'h0629, 1, 0, 0, 0, Z, "arm");
    cyc(16'h0629, 1, 0, 0, 0, Z, "armed_idle");
    cyc(16'h0630, 1, 0, 0, 0, RH, "basic_hit");
    cyc(16'h0630, 1, 0, 0, 0, R, "basic_hit_drop");
    cyc(16'h0630, 1, 0, 0, 1, Z, "basic_stop");
    for (int i = 0; i < 100; i++) cyc(16'h0630, 1, 0, 0, 0, Z, "no_rering");
    bus.alarm_time = 16'h2355;
    cyc(16'h2354, 1, 0, 0, 0, Z, "wrap_pre");
    cyc(16'h2355, 1, 0, 0, 0, RH, "wrap_hit");
    cyc(16'h2355, 1, 0, 1, 0, S, "wrap_snooze");
    cyc(16'h0003, 1, 0, 0, 0, S, "wrap_wait");
    cyc(16'h0004, 1, 0, 0, 0, RH, "wrap_rering");
    cyc(16'h0004, 1, 0, 0, 1, Z, "wrap_stop");
    bus.alarm_time = 16'h0100;
    cyc(16'h0059, 1, 0, 0, 0, Z, "lim_pre");
    cyc(16'h0100, 1, 0, 0, 0, RH, "lim_hit");
    cyc(16'h0100, 1, 0, 1, 0, S, "lim_snz1");
    cyc(16'h0108, 1, 0, 0, 0, S, "lim_wait1");
    cyc(16'h0109, 1, 0, 0, 0, RH, "lim_ring2");
    cyc(16'h0109, 1, 0, 1, 0, S, "lim_snz2");
    cyc(16'h0117, 1, 0, 0, 0, S, "lim_wait2");
    cyc(16'h0118, 1, 0, 0, 0, RH, "lim_ring3");
    cyc(16'h0118, 1, 0, 1, 0, S, "lim_snz3");
    cyc(16'h0126, 1, 0, 0, 0, S, "lim_wait3");
    cyc(16'h0127, 1, 0, 0, 0, RH, "lim_ring4");
    cyc(16'h0127, 1, 0, 1, 0, Z, "lim_snz4_stops");
    cyc(16'h0059, 1, 0, 0, 0, Z, "lim_armed");
    cyc(16'h0100, 1, 0, 0, 0, RH, "lim_fresh_hit");
    cyc(16'h0100, 1, 0, 1, 0, S, "lim_cnt_cleared");
    cyc(16'h0100, 1, 0, 0, 1, Z, "snoozed_stop");
    cyc(16'h0101, 1, 0, 0, 0, Z, "after_stop");
    bus.alarm_time = 16'h0700;
    cyc(16'h0659, 1, 0, 0, 0, Z, "to_pre");
    cyc(16'h0700, 1, 1, 0, 0, RH, "to_entry_tick");
    cyc(16'h0700, 1, 1, 0, 0, R, "to_tick1");
    cyc(16'h0700, 1, 1, 0, 0, R, "to_tick2");
    cyc(16'h0700, 1, 0, 0, 0, R, "to_gap");
    cyc(16'h0700, 1, 1, 0, 0, R, "to_tick3");
    cyc(16'h0700, 1, 1, 0, 0, R, "to_tick4");
    cyc(16'h0700, 1, 1, 0, 0, Z, "to_tick5");
    cyc(16'h0700, 1, 0, 0, 0, Z, "to_no_rering");
    bus.alarm_time = 16'h0800;
    cyc(16'h0759, 1, 0, 0, 0, Z, "pri_pre");
    cyc(16'h0800, 1, 0, 0, 0, RH, "pri_hit");
    cyc(16'h0800, 1, 0, 1, 1, Z, "pri_stop_over_snz");
    cyc(16'h0801, 1, 0, 1, 0, Z, "pri_snz_ignored");
    bus.alarm_time = 16'h0810;
    cyc(16'h0809, 1, 0, 0, 0, Z, "dis_pre");
    cyc(16'h0810, 1, 0, 0, 0, RH, "dis_hit");
    cyc(16'h0810, 1, 0, 1, 0, S, "dis_snooze");
    cyc(16'h0811, 0, 0, 0, 0, Z, "dis_off");
    cyc(16'h0810, 0, 0, 0, 0, Z, "dis_off_match");
    cyc(16'h0810, 1, 0, 0, 0, Z, "reen_arm");
    cyc(16'h0810, 1, 0, 0, 0, RH, "reen_ring");
    cyc(16'h0810, 1, 0, 0, 1, Z, "reen_stop");
    bus.alarm_time = 16'h0900;
    cyc(16'h0859, 1, 0, 0, 0, Z, "rst_pre");
    cyc(16'h0900, 1, 0, 0, 0, RH, "rst_hit");
    cyc(16'h0900, 1, 0, 0, 0, R, "rst_ringing");
    @(negedge clk);
    #2 clr = 1'b1;
    #1 check("rst_async_drop", {bus.ring, bus.snoozing, bus.alarm_hit}, Z);
    @(negedge clk);
    clr = 1'b0;
    push(Z, "rst_rearm");
    cyc(16'h0900, 1, 0, 0, 0, RH, "rst_rering");
    cyc(16'h0900, 1, 0, 0, 1, Z, "rst_stop");
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
